// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Brief    : SPI-flash-style responder (mode 0) in front of a byte memory;
//            supports READ 03h, PP 02h, WREN 06h, RDSR 05h, RDID 9Fh.
//            Optional busy emulation when SPI_RESP_BUSY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          ADDR_W      = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          BUSY_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_sclk,
    input  logic              in_mosi,
    input  logic              in_cs_n,
    output logic              out_miso,
    output logic              out_miso_oe,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [7:0]        out_mem_wdata,
    output logic              out_mem_we,
    input  logic [7:0]        in_mem_rdata,
    output logic [7:0]        out_status,
    output logic              out_active
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_PROG   = 3'd4,
        ST_RDSR   = 3'd5,
        ST_RDID   = 3'd6,
        ST_IGNORE = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] c_page_mask = ADDR_W'(8'hFF);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

    logic [2:0]        sclk_sync_q;
    logic [2:0]        cs_sync_q;
    logic [1:0]        mosi_sync_q;
    logic [1:0]        flush_cnt_q;
    logic              armed_q;

    state_t            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [7:0]        tx_q, tx_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic              miso_q, miso_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              is_prog_q, is_prog_d;
    logic              wel_q, wel_d;
    logic              wren_pend_q, wren_pend_d;
    logic              prog_wrote_q, prog_wrote_d;

    logic              w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;
    logic [7:0]        w_rx_byte;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_page_inc;
    logic              w_wip;
    logic              w_start_busy;
    logic [7:0]        w_status;
    logic [7:0]        w_id_byte;
    logic [7:0]        w_tx_src;
    logic              w_tx_state;

    // After reset the cs_n synchronizer is forced high; a falling edge is only
    // trusted once the real pin level has been seen high, so a transaction that
    // was cut by reset cannot resume without a fresh select.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            flush_cnt_q <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], in_sclk};
            cs_sync_q   <= {cs_sync_q[1:0], in_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], in_mosi};
            if (flush_cnt_q != 2'd3) begin
                flush_cnt_q <= flush_cnt_q + 2'd1;
            end else if (cs_sync_q[2]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign w_sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign w_cs_fall   = armed_q & ~cs_sync_q[1] & cs_sync_q[2];
    assign w_cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign w_mosi      = mosi_sync_q[1];

    assign w_rx_byte   = {rx_q, w_mosi};
    assign w_addr_next = {addr_q, w_mosi};
    assign w_page_inc  = (mem_addr_q & ~c_page_mask) | ((mem_addr_q + c_addr_one) & c_page_mask);
    assign w_status    = {6'b0, wel_q, w_wip};
    assign w_tx_state  = (state_q == ST_READ) || (state_q == ST_RDSR) || (state_q == ST_RDID);

    always_comb begin
        case (id_idx_q)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = 8'h00;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_READ: w_tx_src = in_mem_rdata;
            ST_RDSR: w_tx_src = w_status;
            ST_RDID: w_tx_src = w_id_byte;
            default: w_tx_src = 8'h00;
        endcase
    end

`ifdef SPI_RESP_BUSY_EN
    localparam int c_busy_w = $clog2(BUSY_CYCLES + 1);

    logic [c_busy_w-1:0] busy_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
        end else if (w_start_busy) begin
            busy_cnt_q <= c_busy_w'(BUSY_CYCLES);
        end else if (busy_cnt_q != '0) begin
            busy_cnt_q <= busy_cnt_q - c_busy_w'(1);
        end
    end

    assign w_wip = (busy_cnt_q != '0);
`else
    logic w_unused_cfg;

    assign w_wip        = 1'b0;
    assign w_unused_cfg = w_start_busy ^ (BUSY_CYCLES != 0);
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        addr_d       = addr_q;
        mem_addr_d   = mem_addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        tx_d         = tx_q;
        tx_cnt_d     = tx_cnt_q;
        miso_d       = miso_q;
        id_idx_d     = id_idx_q;
        is_prog_d    = is_prog_q;
        wel_d        = wel_q;
        wren_pend_d  = wren_pend_q;
        prog_wrote_d = prog_wrote_q;
        w_start_busy = 1'b0;

        // Page-local advance happens the cycle after the write strobe.
        if (we_q) begin
            mem_addr_d = w_page_inc;
        end

        if (state_q == ST_IDLE) begin
            miso_d = 1'b0;
            if (w_cs_fall) begin
                state_d      = ST_CMD;
                bit_cnt_d    = 5'd0;
                wren_pend_d  = 1'b0;
                prog_wrote_d = 1'b0;
            end
        end else if (w_cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            if (state_q == ST_IGNORE && wren_pend_q) begin
                wel_d = 1'b1;
            end
            if (state_q == ST_PROG && wel_q) begin
                wel_d        = 1'b0;
                w_start_busy = prog_wrote_q;
            end
        end else if (w_sclk_rise) begin
            case (state_q)
                ST_CMD: begin
                    rx_d      = w_rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        tx_cnt_d  = 3'd0;
                        id_idx_d  = 2'd0;
                        if (w_wip && w_rx_byte != 8'h05) begin
                            state_d = ST_IGNORE;
                        end else begin
                            case (w_rx_byte)
                                8'h03: begin
                                    state_d   = ST_ADDR;
                                    is_prog_d = 1'b0;
                                end
                                8'h02: begin
                                    state_d   = ST_ADDR;
                                    is_prog_d = 1'b1;
                                end
                                8'h06: begin
                                    state_d     = ST_IGNORE;
                                    wren_pend_d = 1'b1;
                                end
                                8'h05:   state_d = ST_RDSR;
                                8'h9F:   state_d = ST_RDID;
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    addr_d    = w_addr_next[ADDR_W-2:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        mem_addr_d = w_addr_next;
                        bit_cnt_d  = 5'd0;
                        state_d    = is_prog_q ? ST_PROG : ST_READ;
                    end
                end
                ST_PROG: begin
                    rx_d      = w_rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        if (wel_q) begin
                            we_d         = 1'b1;
                            wdata_d      = w_rx_byte;
                            prog_wrote_d = 1'b1;
                        end
                    end
                end
                ST_IGNORE: wren_pend_d = 1'b0;
                default: ;
            endcase
        end else if (w_sclk_fall && w_tx_state) begin
            tx_cnt_d = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd0) begin
                miso_d = w_tx_src[7];
                tx_d   = {w_tx_src[6:0], 1'b0};
                if (state_q == ST_READ) begin
                    mem_addr_d = mem_addr_q + c_addr_one;
                end
                if (state_q == ST_RDID && id_idx_q != 2'd3) begin
                    id_idx_d = id_idx_q + 2'd1;
                end
            end else begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 5'd0;
            rx_q         <= 7'd0;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            wdata_q      <= 8'h00;
            we_q         <= 1'b0;
            tx_q         <= 8'h00;
            tx_cnt_q     <= 3'd0;
            miso_q       <= 1'b0;
            id_idx_q     <= 2'd0;
            is_prog_q    <= 1'b0;
            wel_q        <= 1'b0;
            wren_pend_q  <= 1'b0;
            prog_wrote_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            addr_q       <= addr_d;
            mem_addr_q   <= mem_addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            tx_q         <= tx_d;
            tx_cnt_q     <= tx_cnt_d;
            miso_q       <= miso_d;
            id_idx_q     <= id_idx_d;
            is_prog_q    <= is_prog_d;
            wel_q        <= wel_d;
            wren_pend_q  <= wren_pend_d;
            prog_wrote_q <= prog_wrote_d;
        end
    end

    assign out_miso_oe   = w_tx_state;
    assign out_miso      = w_tx_state & miso_q;
    assign out_mem_addr  = mem_addr_q;
    assign out_mem_wdata = wdata_q;
    assign out_mem_we    = we_q;
    assign out_status    = w_status;
    assign out_active    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter: ADDR_W, 16, memory address width (low ADDR_W bits of 24-bit flash address used).
REQ-002 Parameter: JEDEC_ID, 24'hEF4016, bytes returned by 0x9F, MSB first.
REQ-003 Parameter: BUSY_CYCLES, 64, clk cycles WIP stays set after a page program.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_sclk  input  1  SPI clock from controller, mode 0, asynchronous to clk.
REQ-007 in_mosi  input  1  serial data from controller.
REQ-008 in_cs_n  input  1  chip select, active low.
REQ-009 out_miso  output  1  serial data to controller.
REQ-010 out_miso_oe  output  1  high while responder drives out_miso.
REQ-011 out_mem_addr  output  ADDR_W  byte address to backing memory.
REQ-012 out_mem_wdata  output  8  write data to backing memory.
REQ-013 out_mem_we  output  1  one-cycle write strobe.
REQ-014 in_mem_rdata  input  8  read data, valid one clk after out_mem_addr changes.
REQ-015 out_status  output  8  status register: bit0 WIP, bit1 WEL, others 0.
REQ-016 out_active  output  1  high while a transaction is selected (synced cs_n low).

Function
REQ-017 in_sclk, in_mosi, in_cs_n SHALL pass through 2-flop synchronizers; edges detected in clk domain; in_sclk half-period SHALL be >= 4 clk.
REQ-018 MOSI SHALL be sampled on synced sclk rising edge; out_miso SHALL update on synced sclk falling edge, MSB first.
REQ-019 FSM states: IDLE, CMD, ADDR, READ, PROG, RDSR, RDID, IGNORE.
REQ-020 IDLE->CMD on synced cs_n falling; any state->IDLE on synced cs_n rising, same cycle.
REQ-021 CMD: after 8 bits decode 0x03->ADDR(read), 0x02->ADDR(program), 0x06->IGNORE (WEL set pending), 0x05->RDSR, 0x9F->RDID, other->IGNORE.
REQ-022 While WIP=1 every command except 0x05 SHALL go to IGNORE with no side effects.
REQ-023 ADDR: 24 bits collected; low ADDR_W bits loaded to out_mem_addr on the 24th rising edge.
REQ-024 READ: first data MSB driven on falling edge following last address bit; next byte fetched at each byte boundary; address increments, wraps 2^ADDR_W-1 -> 0.
REQ-025 PROG: each complete received byte SHALL pulse out_mem_we one clk with out_mem_wdata; address increments within 256-byte page only (low 8 bits wrap, upper bits held); ignored if WEL=0.
REQ-026 RDSR: out_status shifted out repeatedly until cs_n rises; RDID: 3 JEDEC_ID bytes then 0x00.
REQ-027 0x06 SHALL set WEL only if cs_n rises exactly after 8 bits; partial trailing bytes SHALL be discarded in all commands.
REQ-028 cs_n rising after PROG with WEL=1 SHALL clear WEL.
REQ-029 out_miso_oe SHALL be 1 only in READ, RDSR, RDID; out_miso 0 when out_miso_oe is 0.

Reset
REQ-030 rst SHALL force IDLE, synchronizers to idle levels (sclk 0, cs_n 1), WEL=0, WIP=0, busy counter 0.
REQ-031 Reset values: out_miso 0, out_miso_oe 0, out_mem_addr 0, out_mem_wdata 0, out_mem_we 0, out_status 0, out_active 0.
REQ-032 rst mid-transaction SHALL abort with no memory write; next transaction needs a fresh cs_n falling edge.

Configuration
REQ-033 Macro SPI_RESP_BUSY_EN defined: cs_n rising ending a valid program SHALL set WIP for exactly BUSY_CYCLES clk, then clear it.
REQ-034 SPI_RESP_BUSY_EN undefined: WIP SHALL remain 0, busy counter absent, REQ-022 never triggers.

Verification
REQ-035 rst, then 0x9F with 32 sclks -> MISO bytes EF 40 16 00, out_miso_oe 1 during data.
REQ-036 0x06, then 0x02 addr 0x0000FE data AA BB CC -> writes FE=AA, FF=BB, 00=CC (page wrap), WEL 0 after cs_n rise.
REQ-037 0x02 without prior 0x06 addr 0x000010 data 55 -> no out_mem_we pulse, status 0x00.
REQ-038 Memory preloaded FFFF=12, 0000=34; 0x03 addr 0x00FFFF, 16 data clocks -> MISO 12 34.
REQ-039 With SPI_RESP_BUSY_EN: after program, 0x05 -> 0x01 during BUSY_CYCLES, 0x00 afterwards; 0x03 during busy -> out_miso_oe stays 0.
REQ-040 cs_n rise after 5 bits of program data byte, and rst asserted mid-address -> no write, FSM IDLE, all outputs at reset values.
